// File: rtl/staged_counter_pkg.sv
// ---------------------------------------------------------------------------
// staged_counter_pkg
// Shared type and helper for the staged event counter and its abstraction
// model. Both import the region enum from here so their region codes stay
// identical.
//
// Contents:
//   counter_stage_e  region code of a count value (codes 0..6, 7 reserved)
//   classify_count   maps a count onto its region, given the two special
//                    values and the all-ones value of the counter width
// ---------------------------------------------------------------------------
package staged_counter_pkg;

   typedef enum bit [2:0] {
      INITIAL = 3'd0,
      STAGE_1 = 3'd1,
      SPVAL_1 = 3'd2,
      STAGE_2 = 3'd3,
      SPVAL_2 = 3'd4,
      STAGE_3 = 3'd5,
      MAXCNTS = 3'd6
   } counter_stage_e;

   // Arguments are 32 bits wide so the counter width can vary without
   // changing the function. An empty region can never be returned because
   // the equality tests for the boundary values are checked before the range
   // above them.
   function automatic counter_stage_e classify_count(
      input logic [31:0] count,
      input logic [31:0] spv1,
      input logic [31:0] spv2,
      input logic [31:0] cnt_max
   );
      counter_stage_e s;
      if (count == 32'd0)        s = INITIAL;
      else if (count < spv1)     s = STAGE_1;
      else if (count == spv1)    s = SPVAL_1;
      else if (count < spv2)     s = STAGE_2;
      else if (count == spv2)    s = SPVAL_2;
      else if (count < cnt_max)  s = STAGE_3;
      else                       s = MAXCNTS;
      return s;
   endfunction

endpackage

// File: rtl/staged_counter_classify.sv
// ---------------------------------------------------------------------------
// staged_counter_classify
// Purely combinational region classifier. It is applied to the next-count
// value so that the registered stage lands in the same cycle as the count it
// describes.
//
// Ports:
//   count_next  in   BIT_WIDTH  count value about to be registered
//   stage_next  out  3          region code of count_next
// ---------------------------------------------------------------------------
module staged_counter_classify
   import staged_counter_pkg::*;
#(
   parameter int BIT_WIDTH = 8,
   parameter int SPVALUE_1 = 200,
   parameter int SPVALUE_2 = 249
) (
   input  logic [BIT_WIDTH-1:0] count_next,
   output logic [2:0]           stage_next
);

   localparam logic [BIT_WIDTH-1:0] CNT_MAX = '1;

   // Widen every operand to the function's 32-bit argument type.
   always_comb begin
      stage_next = classify_count(32'(count_next), 32'(SPVALUE_1),
                                  32'(SPVALUE_2), 32'(CNT_MAX));
   end

endmodule

// File: rtl/staged_counter.sv
// ---------------------------------------------------------------------------
// staged_counter
// Free-running event counter with a registered region code and one-cycle
// pulses when the count first reaches either special value or all-ones, and
// when it wraps from all-ones to zero. All outputs come straight from flops.
//
// Ports:
//   clk       in   1          rising-edge clock
//   rst       in   1          synchronous active-high reset
//   clr       in   1          clear count to 0 (beats incr)
//   incr      in   1          increment count by 1, modulo 2^BIT_WIDTH
//   counts    out  BIT_WIDTH  current count
//   stage     out  3          region code of counts (counter_stage_e)
//   hit_spv1  out  1          pulse: counts just became SPVALUE_1
//   hit_spv2  out  1          pulse: counts just became SPVALUE_2
//   hit_max   out  1          pulse: counts just became all-ones
//   wrap      out  1          pulse: counts just wrapped to 0
//
// Build option: define STAGED_COUNTER_SVA_EN to compile the embedded
// concurrent assertions; without it the block has no assertion code.
// ---------------------------------------------------------------------------
module staged_counter
   import staged_counter_pkg::*;
#(
   parameter int BIT_WIDTH = 8,
   parameter int SPVALUE_1 = 200,
   parameter int SPVALUE_2 = 249
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 incr,
   output logic [BIT_WIDTH-1:0] counts,
   output logic [2:0]           stage,
   output logic                 hit_spv1,
   output logic                 hit_spv2,
   output logic                 hit_max,
   output logic                 wrap
);

   localparam logic [BIT_WIDTH-1:0] CNT_MAX  = '1;
   localparam logic [BIT_WIDTH-1:0] SPV1_VAL = BIT_WIDTH'(SPVALUE_1);
   localparam logic [BIT_WIDTH-1:0] SPV2_VAL = BIT_WIDTH'(SPVALUE_2);

   // Reject parameter sets whose regions would be out of order or would
   // collide with zero or all-ones.
   if (!((SPVALUE_1 > 0) && (SPVALUE_1 < SPVALUE_2) &&
         (SPVALUE_2 < (2 ** BIT_WIDTH) - 1))) begin : g_param_error
      $fatal(1, "staged_counter: require 0 < SPVALUE_1 < SPVALUE_2 < 2**BIT_WIDTH-1");
   end

   logic [BIT_WIDTH-1:0] counts_q, counts_d;
   logic [2:0]           stage_q, stage_d;
   logic                 hit_spv1_q, hit_spv1_d;
   logic                 hit_spv2_q, hit_spv2_d;
   logic                 hit_max_q, hit_max_d;
   logic                 wrap_q, wrap_d;
   logic                 step_up;

   // Clear has priority over increment; reset is applied in the register
   // process so it beats both. Pulses only fire on a real increment, so a
   // clear (even with incr high) never raises one.
   always_comb begin
      counts_d   = counts_q;
      step_up    = incr & ~clr;
      if (clr)
         counts_d = '0;
      else if (incr)
         counts_d = counts_q + BIT_WIDTH'(1);
      hit_spv1_d = step_up && (counts_d == SPV1_VAL);
      hit_spv2_d = step_up && (counts_d == SPV2_VAL);
      hit_max_d  = step_up && (counts_d == CNT_MAX);
      wrap_d     = step_up && (counts_q == CNT_MAX);
   end

   // Classify the next count so the stage register is always in step with
   // the count register.
   staged_counter_classify #(
      .BIT_WIDTH (BIT_WIDTH),
      .SPVALUE_1 (SPVALUE_1),
      .SPVALUE_2 (SPVALUE_2)
   ) u_classify (
      .count_next (counts_d),
      .stage_next (stage_d)
   );

   // Count, stage and pulse registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         counts_q   <= '0;
         stage_q    <= 3'(INITIAL);
         hit_spv1_q <= 1'b0;
         hit_spv2_q <= 1'b0;
         hit_max_q  <= 1'b0;
         wrap_q     <= 1'b0;
      end else begin
         counts_q   <= counts_d;
         stage_q    <= stage_d;
         hit_spv1_q <= hit_spv1_d;
         hit_spv2_q <= hit_spv2_d;
         hit_max_q  <= hit_max_d;
         wrap_q     <= wrap_d;
      end
   end

   assign counts   = counts_q;
   assign stage    = stage_q;
   assign hit_spv1 = hit_spv1_q;
   assign hit_spv2 = hit_spv2_q;
   assign hit_max  = hit_max_q;
   assign wrap     = wrap_q;

`ifdef STAGED_COUNTER_SVA_EN
   // Structural invariants of the counter, all suspended while in reset.
   a_stage_matches : assert property (@(posedge clk) disable iff (rst)
      stage_q == 3'(classify_count(32'(counts_q), 32'(SPVALUE_1),
                                   32'(SPVALUE_2), 32'(CNT_MAX))));
   a_stage_legal : assert property (@(posedge clk) disable iff (rst)
      stage_q != 3'd7);
   a_pulse_onehot : assert property (@(posedge clk) disable iff (rst)
      $onehot0({hit_spv1_q, hit_spv2_q, hit_max_q, wrap_q}));
   a_clr_zero : assert property (@(posedge clk) disable iff (rst)
      clr |=> (counts_q == '0));
   a_pulse_incr : assert property (@(posedge clk) disable iff (rst)
      (hit_spv1_q | hit_spv2_q | hit_max_q | wrap_q) |-> $past(incr));
`endif

endmodule

// File: tb/tb_staged_counter.sv
// ---------------------------------------------------------------------------
// tb_staged_counter
// Drives two counters from the same inputs: the default configuration
// (200/249) and a tight one (1/2) where the lower regions are empty. Each
// has a behavioural model that works from plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_staged_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       clr = 1'b0;
   logic       incr = 1'b0;

   logic [7:0] counts_a, counts_b;
   logic [2:0] stage_a, stage_b;
   logic       hit_spv1_a, hit_spv2_a, hit_max_a, wrap_a;
   logic       hit_spv1_b, hit_spv2_b, hit_max_b, wrap_b;

   int total = 0;
   int bad   = 0;

   int m_spv1[2]  = '{200, 1};
   int m_spv2[2]  = '{249, 2};
   int m_count[2] = '{0, 0};
   int m_stage[2] = '{0, 0};
   int m_spv1p[2] = '{0, 0};
   int m_spv2p[2] = '{0, 0};
   int m_maxp[2]  = '{0, 0};
   int m_wrapp[2] = '{0, 0};

   staged_counter #(.BIT_WIDTH(8), .SPVALUE_1(200), .SPVALUE_2(249)) dut_a (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .incr     (incr),
      .counts   (counts_a),
      .stage    (stage_a),
      .hit_spv1 (hit_spv1_a),
      .hit_spv2 (hit_spv2_a),
      .hit_max  (hit_max_a),
      .wrap     (wrap_a)
   );

   staged_counter #(.BIT_WIDTH(8), .SPVALUE_1(1), .SPVALUE_2(2)) dut_b (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .incr     (incr),
      .counts   (counts_b),
      .stage    (stage_b),
      .hit_spv1 (hit_spv1_b),
      .hit_spv2 (hit_spv2_b),
      .hit_max  (hit_max_b),
      .wrap     (wrap_b)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // Region code as a count of thresholds the value has passed: each
   // boundary value adds one on reaching it and one more on leaving it.
   function automatic int model_stage(int c, int s1, int s2);
      return int'(c > 0) + int'(c >= s1) + int'(c > s1) +
             int'(c >= s2) + int'(c > s2) + int'(c == 255);
   endfunction

   // Advance both reference models by one clock with the given inputs.
   task automatic modelStep(bit r, bit c, bit i);
      for (int k = 0; k < 2; k++) begin
         int prev;
         prev       = m_count[k];
         m_spv1p[k] = 0;
         m_spv2p[k] = 0;
         m_maxp[k]  = 0;
         m_wrapp[k] = 0;
         if (r || c)
            m_count[k] = 0;
         else if (i)
            m_count[k] = (prev + 1) % 256;
         if (!r && !c && i) begin
            m_spv1p[k] = int'(m_count[k] == m_spv1[k]);
            m_spv2p[k] = int'(m_count[k] == m_spv2[k]);
            m_maxp[k]  = int'(m_count[k] == 255);
            m_wrapp[k] = int'(prev == 255);
         end
         m_stage[k] = model_stage(m_count[k], m_spv1[k], m_spv2[k]);
      end
   endtask

   // One counted comparison.
   task automatic checkEq(string tag, int observed, int expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs, step past the edge and advance the model.
   task automatic applyStimulus(bit r, bit c, bit i);
      rst  = r;
      clr  = c;
      incr = i;
      @(posedge clk);
      #1;
      modelStep(r, c, i);
   endtask

   // Compare every output of both counters with their models.
   task automatic checkOutput(string tag);
      checkEq({tag, "/a/counts"}, int'(counts_a), m_count[0]);
      checkEq({tag, "/a/stage"},  int'(stage_a),  m_stage[0]);
      checkEq({tag, "/a/spv1"},   int'(hit_spv1_a), m_spv1p[0]);
      checkEq({tag, "/a/spv2"},   int'(hit_spv2_a), m_spv2p[0]);
      checkEq({tag, "/a/max"},    int'(hit_max_a),  m_maxp[0]);
      checkEq({tag, "/a/wrap"},   int'(wrap_a),     m_wrapp[0]);
      checkEq({tag, "/b/counts"}, int'(counts_b), m_count[1]);
      checkEq({tag, "/b/stage"},  int'(stage_b),  m_stage[1]);
      checkEq({tag, "/b/spv1"},   int'(hit_spv1_b), m_spv1p[1]);
      checkEq({tag, "/b/spv2"},   int'(hit_spv2_b), m_spv2p[1]);
      checkEq({tag, "/b/max"},    int'(hit_max_b),  m_maxp[1]);
      checkEq({tag, "/b/wrap"},   int'(wrap_b),     m_wrapp[1]);
   endtask

   // Directed test-plan steps followed by a randomized phase.
   initial begin
      // Reset state.
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("reset");
      checkEq("reset_counts", int'(counts_a), 0);
      checkEq("reset_stage", int'(stage_a), 0);

      // Count up to the first special value.
      for (int n = 0; n < 200; n++) begin
         applyStimulus(1'b0, 1'b0, 1'b1);
         checkOutput("up_to_spv1");
      end
      checkEq("spv1_counts", int'(counts_a), 200);
      checkEq("spv1_stage", int'(stage_a), 2);
      checkEq("spv1_pulse", int'(hit_spv1_a), 1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("past_spv1");
      checkEq("past_spv1_stage", int'(stage_a), 3);
      checkEq("past_spv1_pulse", int'(hit_spv1_a), 0);

      // Reach the second special value and idle on it.
      while (m_count[0] < 249) begin
         applyStimulus(1'b0, 1'b0, 1'b1);
         checkOutput("up_to_spv2");
      end
      checkEq("spv2_pulse", int'(hit_spv2_a), 1);
      for (int n = 0; n < 3; n++) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         checkOutput("hold_spv2");
         checkEq("hold_spv2_stage", int'(stage_a), 4);
         checkEq("hold_spv2_pulse", int'(hit_spv2_a), 0);
      end

      // Reach all-ones, then wrap.
      while (m_count[0] < 255) begin
         applyStimulus(1'b0, 1'b0, 1'b1);
         checkOutput("up_to_max");
      end
      checkEq("max_pulse", int'(hit_max_a), 1);
      checkEq("max_stage", int'(stage_a), 6);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("wrap");
      checkEq("wrap_pulse", int'(wrap_a), 1);
      checkEq("wrap_counts", int'(counts_a), 0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("after_wrap");

      // Clear and increment together at 150.
      while (m_count[0] < 150) begin
         applyStimulus(1'b0, 1'b0, 1'b1);
         checkOutput("up_to_150");
      end
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput("clr_incr");
      checkEq("clr_incr_counts", int'(counts_a), 0);
      checkEq("clr_incr_stage", int'(stage_a), 0);

      // Reset while incrementing at 230.
      while (m_count[0] < 230) begin
         applyStimulus(1'b0, 1'b0, 1'b1);
         checkOutput("up_to_230");
      end
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("rst_mid");
      checkEq("rst_mid_counts", int'(counts_a), 0);

      // Tight configuration walks INITIAL -> SPVAL_1 -> SPVAL_2 -> STAGE_3.
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("tight1");
      checkEq("tight1_stage", int'(stage_b), 2);
      checkEq("tight1_spv1", int'(hit_spv1_b), 1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("tight2");
      checkEq("tight2_stage", int'(stage_b), 4);
      checkEq("tight2_spv2", int'(hit_spv2_b), 1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("tight3");
      checkEq("tight3_stage", int'(stage_b), 5);

      // Randomized mix: mostly increments, occasional clears and resets.
      for (int n = 0; n < 1500; n++) begin
         bit r, c, i;
         r = ($urandom_range(0, 99) == 0);
         c = ($urandom_range(0, 39) == 0);
         i = ($urandom_range(0, 3) != 0);
         applyStimulus(r, c, i);
         checkOutput("random");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/staged_counter.md
# staged_counter

Concrete free-running event counter whose value space is split by two special values into seven regions. It keeps a registered region code (`stage`) consistent with `counts` in every cycle, and pulses a one-cycle flag when each special value or the maximum is reached. It is the design-side counterpart of the team's counter abstraction model: formal runs either check it against that model or replace it with the model.

## Interface
- `BIT_WIDTH`, 8, width of `counts`.
- `SPVALUE_1`, 200, first special value; must satisfy 0 < `SPVALUE_1` < `SPVALUE_2`.
- `SPVALUE_2`, 249, second special value; must satisfy `SPVALUE_2` < 2^`BIT_WIDTH`−1.
- Any parameter violation is an elaboration-time fatal error.

- `clk`  input  1  sole clock, rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `clr`  input  1  clear counter to 0.
- `incr`  input  1  increment counter by 1.
- `counts`  output  `BIT_WIDTH`  current count.
- `stage`  output  3  region code of `counts` (counter_stage_e).
- `hit_spv1`  output  1  pulse: `counts` just became `SPVALUE_1`.
- `hit_spv2`  output  1  pulse: `counts` just became `SPVALUE_2`.
- `hit_max`  output  1  pulse: `counts` just became all-ones.
- `wrap`  output  1  pulse: `counts` just wrapped from all-ones to 0.

## Operation
- Region encoding and ranges:
  - INITIAL=0: `counts` = 0.
  - STAGE_1=1: 0 < `counts` < `SPVALUE_1`.
  - SPVAL_1=2: `counts` = `SPVALUE_1`.
  - STAGE_2=3: `SPVALUE_1` < `counts` < `SPVALUE_2`.
  - SPVAL_2=4: `counts` = `SPVALUE_2`.
  - STAGE_3=5: `SPVALUE_2` < `counts` < all-ones.
  - MAXCNTS=6: `counts` = all-ones.
  - Code 7 is reserved and never driven.
- Next-count priority, highest first:
  - `rst` → 0.
  - `clr` → 0.
  - `incr` → `counts`+1, modulo 2^`BIT_WIDTH`.
  - Otherwise hold.
- `stage` is registered. It equals the classification of the next count, so `stage` always matches `counts` in the same cycle.
- The stage sequence follows the classification. An empty region is skipped; for example, with `SPVALUE_1`=1, an increment from 0 goes INITIAL→SPVAL_1.
- Pulses are registered and set only by an increment:
  - `hit_spv1` when the next count = `SPVALUE_1` and `incr` is high, `clr` low.
  - `hit_spv2` and `hit_max` follow the same rule for their values.
  - `wrap` when `counts` is all-ones and `incr` is high, `clr` low.
- At most one pulse is high per cycle. `clr` never raises a pulse.
- Holding `incr` low on a special value keeps `stage` but drops the pulse after one cycle.
- Simultaneous `clr` and `incr`: `clr` wins; `counts`=0, `stage`=INITIAL, no pulse.

## Timing
- Reset values: `counts`=0, `stage`=INITIAL, all pulses 0. They apply on the first rising edge with `rst` high.
- `rst` mid-count overrides `clr` and `incr` in the same edge.
- Latency: a `clr` or `incr` sampled at edge N is visible on all outputs after edge N. Single-cycle latency, no combinational input-to-output paths.
- Throughput: one increment per cycle sustained. There is no handshake; every sampled `incr` is accepted.
- Each pulse is exactly one cycle wide, aligned with the cycle in which `counts` first shows the new value.

## Configuration
- `STAGED_COUNTER_SVA_EN` defined: embedded concurrent assertions are compiled in, all disabled during `rst`:
  - `stage` equals the classification of `counts`.
  - `stage` is never 7.
  - Pulses are mutually exclusive (`$onehot0`).
  - `clr |=> counts==0`.
  - Each pulse implies `$past(incr)`.
- Undefined: no assertion code is compiled; RTL behaviour is identical.

## Structure
- Package `staged_counter_pkg` holds:
  - typedef enum bit [2:0] `counter_stage_e`, with values as listed above.
  - Function `classify_count` (count, spv1, spv2, width-max) → `counter_stage_e`.
  - Formal abstraction collateral imports the same enum.
- One sub-module, `staged_counter_classify`: combinational, wraps `classify_count` on the next-count value and feeds the `stage` register. The top level holds the count register, the priority mux, and the pulse registers.

## Test plan
- Reset, then 200 consecutive `incr` → `counts`=200, `stage`=2, `hit_spv1` high only in that cycle; the next `incr` gives `stage`=3.
- Count to 255 → `hit_max`=1, `stage`=6; one more `incr` → `counts`=0, `stage`=0, `wrap`=1 for one cycle.
- At `counts`=150, assert `clr` and `incr` together → `counts`=0, `stage`=0, all pulses 0.
- Reach 249, then hold `incr` low for 3 cycles → `stage`=4 held, `hit_spv2` high only in the first cycle.
- At `counts`=230 with `incr` high, assert `rst` → next cycle `counts`=0, `stage`=0, pulses 0.
- With `SPVALUE_1`=1 and `SPVALUE_2`=2, apply three `incr` from 0 → stages 2, 4, 5 in order, with `hit_spv1` then `hit_spv2`.
